// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus, ID read ports and debug port of the integer register file.
// master drives the pipeline/read indices, slave (the register file) returns data.
interface wb_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  mem_rd_data;
  logic [XLEN-1:0]  alu_data;
  logic [4:0]       mem_rd_addr;
  logic             memToReg;
  logic             regWrite;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [4:0]       dbg_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  dbg_data;
  logic [XLEN-1:0]  wb_data;
  logic             wb_valid;
  logic [CNT_W-1:0] wb_count;

  modport master (
    output mem_rd_data, alu_data, mem_rd_addr, memToReg, regWrite,
    output rs1_addr, rs2_addr, dbg_addr,
    input  rs1_data, rs2_data, dbg_data, wb_data, wb_valid, wb_count
  );

  modport slave (
    input  mem_rd_data, alu_data, mem_rd_addr, memToReg, regWrite,
    input  rs1_addr, rs2_addr, dbg_addr,
    output rs1_data, rs2_data, dbg_data, wb_data, wb_valid, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32I write-back stage and 32x32 register file with two ID read ports,
// registered debug read and retired-write counter. Option: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0]  r_regs [NREG];
  logic [XLEN-1:0]  r_dbg_data;
  logic [CNT_W-1:0] r_wb_count;

  logic [XLEN-1:0]  w_wb_data;
  logic             w_wb_valid;
  logic [XLEN-1:0]  w_rs1_data;
  logic [XLEN-1:0]  w_rs2_data;

  // wb_valid gates on regWrite first so X on the other inputs during a bubble
  // resolves to 0 and cannot reach the array or the counter.
  assign w_wb_data  = bus.memToReg ? bus.mem_rd_data : bus.alu_data;
  assign w_wb_valid = bus.regWrite && (bus.mem_rd_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_dbg_data <= '0;
      r_wb_count <= '0;
    end else begin
      r_dbg_data <= (bus.dbg_addr == 5'd0) ? '0 : r_regs[bus.dbg_addr];
      if (w_wb_valid) begin
        r_regs[bus.mem_rd_addr] <= w_wb_data;
        r_wb_count              <= r_wb_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_rs1_data = r_regs[bus.rs1_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (w_wb_valid && (bus.rs1_addr == bus.mem_rd_addr)) begin
      w_rs1_data = w_wb_data;
    end
`endif
    if (rst || (bus.rs1_addr == 5'd0)) begin
      w_rs1_data = '0;
    end
  end

  always_comb begin
    w_rs2_data = r_regs[bus.rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (w_wb_valid && (bus.rs2_addr == bus.mem_rd_addr)) begin
      w_rs2_data = w_wb_data;
    end
`endif
    if (rst || (bus.rs2_addr == 5'd0)) begin
      w_rs2_data = '0;
    end
  end

  assign bus.rs1_data = w_rs1_data;
  assign bus.rs2_data = w_rs2_data;
  assign bus.dbg_data = r_dbg_data;
  assign bus.wb_data  = w_wb_data;
  assign bus.wb_valid = w_wb_valid;
  assign bus.wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array/counter model
// of the architectural register file; built with a 4-bit counter to reach wrap.
module tb_wb_regfile;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;

  wb_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.XLEN(XLEN), .NREG(32), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model
  logic [XLEN-1:0] m_regs [32];
  int unsigned     m_cnt;
  logic [XLEN-1:0] m_dbg;
  logic [XLEN-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input logic [4:0] a, input bit valid,
                                               input logic [4:0] rd, input logic [XLEN-1:0] wb);
    if (rst === 1'b1 || a == 5'd0) return '0;
    if (BYPASS && valid && a == rd) return wb;
    return m_regs[a];
  endfunction

  // driver
  task automatic drive(input logic rst_v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    rst             = rst_v;
    bus.regWrite    = rw;
    bus.memToReg    = m2r;
    bus.mem_rd_addr = rd;
    bus.alu_data    = alu;
    bus.mem_rd_data = mem;
    bus.rs1_addr    = a1;
    bus.rs2_addr    = a2;
    bus.dbg_addr    = ad;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the
  // edge, then check registered outputs just after it.
  task automatic step();
    bit              valid;
    bit              x_in;
    logic [XLEN-1:0] wb;
    @(negedge clk);
    x_in  = $isunknown({bus.memToReg, bus.mem_rd_data, bus.alu_data, bus.mem_rd_addr});
    valid = (bus.regWrite === 1'b1) && (bus.mem_rd_addr != 5'd0);
    wb    = (bus.memToReg === 1'b1) ? bus.mem_rd_data : bus.alu_data;
    if (!x_in) check("wb_data", bus.wb_data, wb);
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, valid});
    check("rs1_data", bus.rs1_data, exp_read(bus.rs1_addr, valid, bus.mem_rd_addr, wb));
    check("rs2_data", bus.rs2_data, exp_read(bus.rs2_addr, valid, bus.mem_rd_addr, wb));
    @(posedge clk);
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = 0;
      m_dbg = '0;
    end else begin
      m_dbg = (bus.dbg_addr == 5'd0) ? '0 : m_regs[bus.dbg_addr];
      if (valid) begin
        m_regs[bus.mem_rd_addr] = wb;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end
    exp_q.push_back(m_dbg);
    #1;
    check("dbg_data", bus.dbg_data, exp_q.pop_front());
    check("wb_count", {28'd0, bus.wb_count}, m_cnt[XLEN-1:0]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 'x;
    m_cnt = 0;
    m_dbg = '0;

    // reset, then preload and reset again
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 1; i < 6; i++) begin
      drive(0, 1, 0, 5'(i), 32'h100 + i, 0, 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 5'd3, 5'd4, 5'd2);
    step();
    check("t1_count", {28'd0, bus.wb_count}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    step();
    check("t1_dbg", bus.dbg_data, 32'd0);

    // write x5 from ALU
    drive(0, 1, 0, 5'd5, 32'h1234_5678, 32'h0, 0, 0, 0);
    step();
    check("t2_count", {28'd0, bus.wb_count}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 5'd5, 0, 5'd5);
    step();
    check("t2_dbg", bus.dbg_data, 32'h1234_5678);

    // load select into x0
    drive(0, 1, 1, 5'd0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    step();
    check("t3_count", {28'd0, bus.wb_count}, 32'd1);

    // collision on x7
    drive(0, 1, 0, 5'd7, 32'h1, 0, 0, 0, 0);
    step();
    drive(0, 1, 1, 5'd7, 0, 32'hA5A5_A5A5, 0, 5'd7, 5'd7);
    step();
    check("t4_dbg_old", bus.dbg_data, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    step();
    check("t4_dbg_new", bus.dbg_data, 32'hA5A5_A5A5);

    // reset beats a concurrent write
    drive(1, 1, 0, 5'd3, 32'hFF, 0, 5'd3, 0, 5'd3);
    step();
    drive(0, 0, 0, 0, 0, 0, 5'd3, 0, 5'd3);
    step();
    check("t5_dbg", bus.dbg_data, 32'd0);
    check("t5_count", {28'd0, bus.wb_count}, 32'd0);

    // 17 valid writes with bubbles in between: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 0, 5'(1 + (i % 31)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      step();
      drive(0, 0, 'x, 'x, 'x, 'x, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0);
      step();
    end
    check("t6_wrap", {28'd0, bus.wb_count}, 32'd1);

    // random traffic, mostly aimed at a few registers to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) begin
        drive(0, 0, 'x, 'x, 'x, 'x, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
      end else begin
        drive(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), rd, $urandom, $urandom,
              ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31)),
              ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
